// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch unit; Avalon-style read, held instr, redirects applied after the delay slot.
// Optional INSTR_FETCH_ALIGN_CHECK_EN: a misaligned next_pc halts with fault instead of being truncated.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  dest,
    output logic [31:0] pc,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        active
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fault
`endif
);
    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, target_q, target_d;
    logic        pending_q, pending_d;
    logic [31:0] raw_pc, next_pc;
    logic        redirect, stop;

    assign raw_pc   = pending_q ? target_q : pc_q + 32'd4;
    assign redirect = pcsrc | jump;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign next_pc = raw_pc;
    assign stop    = (|raw_pc[1:0]) | (next_pc == HALT_ADDR);
    assign fault   = fault_q;
`else
    assign next_pc = raw_pc & ~32'd3;
    assign stop    = next_pc == HALT_ADDR;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pending_d = pending_q;
        target_d  = target_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (!waitrequest) begin
                    state_d = S_HOLD;
                    instr_d = readdata;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    // a redirect seen while a target is pending belongs to the delay slot and is dropped
                    pending_d = !pending_q && redirect;
                    if (!pending_q && redirect) target_d = jump ? jump_target : branch_target;
                    state_d = stop ? S_HALTED : S_FETCH;
                    pc_d    = stop ? pc_q : next_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET;
            pc_q      <= RESET_VECTOR;
            instr_q   <= 32'd0;
            pending_q <= 1'b0;
            target_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pending_q <= pending_d;
            target_q  <= target_d;
        end
    end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else if (state_q == S_HOLD && instr_ready && |raw_pc[1:0]) fault_q <= 1'b1;
    end
`endif

    assign address     = pc_q;
    assign pc          = pc_q;
    assign read        = state_q == S_FETCH;
    assign instr_valid = state_q == S_HOLD;
    assign active      = state_q != S_HALTED;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign dest        = instr_q[20:16];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random handshakes and redirects checked against a transaction-level fetch model.
module tb_instr_fetch;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address, readdata, instr, pc, branch_target = 32'd0, jump_target = 32'd0;
    logic        read, waitrequest = 1'b1, instr_valid, instr_ready = 1'b0;
    logic        pcsrc = 1'b0, jump = 1'b0, active;
    logic [5:0]  op, funct;
    logic [4:0]  dest;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic        fault;
`endif

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .op(op), .funct(funct),
        .dest(dest), .pc(pc), .pcsrc(pcsrc), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .active(active)
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        , .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == RV ? 32'h24020005 : (a * 32'h9E3779B1) ^ 32'h01234567;
    endfunction

    assign readdata = mem(address);

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: phase of the current transaction, PC, held word, pending delay-slot target
    typedef enum int {P_RST, P_FETCH, P_HOLD, P_HALT} phase_t;
    phase_t      ph = P_RST;
    logic [31:0] m_pc = RV, m_instr = 32'd0, m_tgt = 32'd0;
    logic        m_pend = 1'b0, m_fault = 1'b0;

    task automatic tick(input logic wr, input logic rdy, input logic pcs, input logic [31:0] bt,
                        input logic jmp, input logic [31:0] jt);
        logic [31:0] nxt;
        chk("read", {31'd0, read}, {31'd0, ph == P_FETCH});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, ph == P_HOLD});
        chk("active", {31'd0, active}, {31'd0, ph != P_HALT});
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
`endif
        if (ph == P_FETCH || ph == P_RST) chk("address", address, m_pc);
        if (ph == P_RST) begin
            chk("rst_pc", pc, RV);
            chk("rst_instr", instr, 32'd0);
        end
        if (ph == P_HOLD) begin
            chk("instr", instr, m_instr);
            chk("pc", pc, m_pc);
            chk("op", {26'd0, op}, {26'd0, m_instr[31:26]});
            chk("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
            chk("dest", {27'd0, dest}, {27'd0, m_instr[20:16]});
        end
        waitrequest = wr; instr_ready = rdy; pcsrc = pcs; branch_target = bt; jump = jmp; jump_target = jt;
        case (ph)
            P_RST: ph = P_FETCH;
            P_FETCH: if (!wr) begin ph = P_HOLD; m_instr = mem(m_pc); end
            P_HOLD: if (rdy) begin
                if (m_pend) begin nxt = m_tgt; m_pend = 1'b0; end
                else begin
                    nxt = m_pc + 32'd4;
                    if (pcs || jmp) begin m_pend = 1'b1; m_tgt = jmp ? jt : bt; end
                end
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
                if (nxt[1:0] != 2'b00) begin ph = P_HALT; m_fault = 1'b1; end
                else if (nxt == 32'd0) ph = P_HALT;
`else
                nxt[1:0] = 2'b00;
                if (nxt == 32'd0) ph = P_HALT;
`endif
                else begin ph = P_FETCH; m_pc = nxt; end
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        ph = P_RST; m_pc = RV; m_pend = 1'b0; m_fault = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = RV + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
`ifndef INSTR_FETCH_ALIGN_CHECK_EN
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
        return t;
    endfunction

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++)
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 6) == 0,
                 rnd_tgt(), $urandom_range(0, 8) == 0, rnd_tgt());
    endtask

    task automatic jump_and_halt(input logic [31:0] jt);
        int b;
        b = 0;
        while (!m_pend && ph != P_HALT && b < 200) begin tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, jt); b++; end
        while (ph != P_HALT && b < 400) begin
            tick($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b0, 32'd0, 1'b0, 32'd0);
            b++;
        end
        chk("halt_reached", {31'd0, ph == P_HALT}, 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, RV, 1'b1, RV);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) tick(i < 3, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, i == 5, 1'b0, 32'd0, 1'b0, 32'd0);
        rand_run(600);
        for (int b = 0; b < 50 && ph != P_FETCH; b++) tick(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        #2;
        chk("midread_read", {31'd0, read}, {31'd0, ph == P_FETCH});
        do_reset();
        rand_run(200);
        jump_and_halt(32'hFFFFFFF8);
        do_reset();
        rand_run(300);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        jump_and_halt(32'hBFC00102);
        do_reset();
`endif
        jump_and_halt(32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the bus-based MIPS CPU. It drives instruction reads on the Avalon-style memory port and holds the fetched word until the datapath accepts it. It presents `op`, `funct` and `dest` to the controller. It takes back the controller's `pcsrc`/`jump` decisions and their targets, and applies them after the MIPS branch-delay slot.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'hBFC00000: address of the first fetch after reset.
- `HALT_ADDR`, default 32'h00000000: a fetch address equal to this halts the unit.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  out  32  memory read address; equals the current PC.
- `read`  out  1  read request.
- `waitrequest`  in  1  memory stall; a read completes on an edge where `read=1` and `waitrequest=0`.
- `readdata`  in  32  instruction word; captured on the completing edge.
- `instr`  out  32  held instruction.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  datapath accepts `instr` on an edge where `instr_valid=1`.
- `op`  out  6  `instr[31:26]`, to the controller.
- `funct`  out  6  `instr[5:0]`, to the controller.
- `dest`  out  5  `instr[20:16]`, to the controller.
- `pc`  out  32  address of the held `instr`.
- `pcsrc`  in  1  taken branch for the held instruction.
- `branch_target`  in  32  target used when `pcsrc=1`.
- `jump`  in  1  jump for the held instruction.
- `jump_target`  in  32  target used when `jump=1`; takes priority over `branch_target`.
- `active`  out  1  high until the unit halts.
- `fault`  out  1  misaligned redirect; present only under the macro in Configuration.

## Operation
States:
- **RESET**: entered asynchronously while `reset_n=0`.
- **FETCH**: `read=1`, waiting for `waitrequest=0`.
- **HOLD**: `instr_valid=1`, waiting for `instr_ready`.
- **HALTED**: terminal until reset.

Transitions:
- **RESET → FETCH** on the first edge with `reset_n=1`. PC is `RESET_VECTOR`.
- **FETCH → HOLD** on the completing edge. `instr` is loaded from `readdata`.
- **HOLD → FETCH** on accept. PC loads `next_pc`.
- **HOLD → HALTED** on accept when `next_pc == HALT_ADDR`. No read is issued to `HALT_ADDR`.

Redirect and delay slot:
- `next_pc` is the pending target if one is armed, otherwise PC+4.
- `pcsrc`/`jump` are sampled only on the accept edge.
- If either is high and no target is pending, the selected target is stored and pending is armed. The following fetch is PC+4 (the delay slot).
- Accepting the delay-slot instruction consumes the pending target and clears pending.
- A redirect asserted while accepting the delay-slot instruction is ignored; the pending target wins.

Outputs and arithmetic:
- `op`/`funct`/`dest`/`pc` are combinational from the held registers and are valid in HOLD.
- All PC arithmetic is modulo 2^32. PC+4 from 32'hFFFFFFFC wraps to 0, which is a halt.
- `address` is stable and `read` stays high throughout FETCH, regardless of `waitrequest`.
- `instr_ready` outside HOLD is ignored.

Reset values:
- `read=0`, `address=RESET_VECTOR`, `instr=0`, `instr_valid=0`, `pc=RESET_VECTOR`.
- `active=1`, `fault=0`, pending cleared.
- Reset asserted mid-read drops `read` immediately; the read is abandoned.

## Timing
- Fetch latency: `instr_valid` rises on the edge where `waitrequest` is first sampled low. With zero wait states, `read` is high for 1 cycle.
- Throughput: 2 cycles per instruction at best (FETCH + HOLD, accepted in its first cycle). Each wait state adds 1 cycle.
- After accept, `read` rises on the same edge that drops `instr_valid`.
- `active` falls on the accept edge that selects `HALT_ADDR`.

## Configuration
- `INSTR_FETCH_ALIGN_CHECK_EN` defined:
  - A `next_pc` with bits [1:0] nonzero sends the unit to HALTED with `fault=1` and `active=0`.
  - No read is issued to that address.
- Undefined:
  - `fault` port is absent.
  - Bits [1:0] of every `next_pc` are forced to 0 and fetching continues.

## Test plan
- Reset release, `waitrequest=0`, memory returns 32'h24020005 → `address=BFC00000` with `read=1` in cycle 1; `instr_valid=1`, `op=6'h09`, `dest=5'd2`, `pc=BFC00000` in cycle 2.
- `waitrequest` high for 3 cycles during the first read → `read` high 4 cycles, `address` constant, `instr_valid` delayed 3 cycles.
- `instr_ready=0` for 5 cycles in HOLD → `instr`/`pc` unchanged, `read=0`, then a single fetch of BFC00004 after accept.
- Accept at `pc=BFC00010` with `pcsrc=1`, `branch_target=BFC00100` → next fetches are BFC00014, then BFC00100.
- Delay-slot accept with `jump=1`, `jump_target=BFC00800` → ignored; the fetch goes to the pending target.
- `jump=1`, `jump_target=0` → the delay slot is fetched, then `active=0` in HALTED with no read to 0. With the macro defined, `jump_target=BFC00102` → `fault=1` after the delay slot.
